// File: rtl/button_press_decoder_if.sv
// button_press_decoder_if: raw pin in, debounced level and event strobes out.
interface button_press_decoder_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press_pulse;
  logic long_press_pulse;
  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, short_press_pulse, long_press_pulse
  );
  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, short_press_pulse, long_press_pulse
  );
endinterface

// File: rtl/button_press_decoder.sv
// button_press_decoder: synchronizes, debounces and times a pushbutton into clean one-cycle events.
module button_press_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 960_000,
  parameter int unsigned LONG_CYCLES     = 48_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic                  clk,
  input logic                  reset_n,
  button_press_decoder_if.slave btn
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  typedef enum logic [2:0] {RELEASED, PRESS_PEND, PRESSED, LONG_HELD, REL_PEND_S, REL_PEND_L} state_t;
  state_t        r_state, w_state_n;
  logic [1:0]    r_sync;
  logic [DW-1:0] r_deb_cnt, w_deb_n;
  logic [HW-1:0] r_hold_cnt, w_hold_n;
  logic          r_ev_press, r_ev_rel, r_ev_short, r_ev_long;
  logic          w_ev_press, w_ev_rel, w_ev_short, w_ev_long;
  logic          r_btn_level, r_press, r_rel, r_short, r_long;
  logic          w_p, w_held;
  assign w_p    = r_sync[1] ^ ACTIVE_LOW;
  assign w_held = r_state inside {PRESSED, LONG_HELD, REL_PEND_S, REL_PEND_L};
  always_comb begin
    w_state_n  = r_state;
    w_deb_n    = r_deb_cnt;
    w_hold_n   = r_hold_cnt;
    w_ev_press = 1'b0;
    w_ev_rel   = 1'b0;
    w_ev_short = 1'b0;
    w_ev_long  = 1'b0;
    case (r_state)
      RELEASED: if (w_p) begin
        w_state_n = PRESS_PEND;
        w_deb_n   = DW'(1);
      end
      PRESS_PEND: if (!w_p) begin
        w_state_n = RELEASED;
        w_deb_n   = '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        w_state_n  = PRESSED;
        w_deb_n    = '0;
        w_hold_n   = '0;
        w_ev_press = 1'b1;
      end else w_deb_n = r_deb_cnt + DW'(1);
      PRESSED: begin
        w_hold_n = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1);
        // the long threshold outranks a simultaneous release edge
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_n = LONG_HELD;
          w_ev_long = 1'b1;
        end else if (!w_p) begin
          w_state_n = REL_PEND_S;
          w_deb_n   = DW'(1);
        end
      end
      LONG_HELD: if (!w_p) begin
        w_state_n = REL_PEND_L;
        w_deb_n   = DW'(1);
      end
      REL_PEND_S, REL_PEND_L: if (w_p) begin
        w_state_n = (r_state == REL_PEND_S) ? PRESSED : LONG_HELD;
        w_deb_n   = '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        w_state_n  = RELEASED;
        w_deb_n    = '0;
        w_hold_n   = '0;
        w_ev_rel   = 1'b1;
        w_ev_short = (r_state == REL_PEND_S);
      end else w_deb_n = r_deb_cnt + DW'(1);
      default: w_state_n = RELEASED;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync      <= {2{ACTIVE_LOW}};
      r_state     <= RELEASED;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_ev_press  <= 1'b0;
      r_ev_rel    <= 1'b0;
      r_ev_short  <= 1'b0;
      r_ev_long   <= 1'b0;
      r_btn_level <= 1'b0;
      r_press     <= 1'b0;
      r_rel       <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], btn.btn_raw};
      r_state     <= w_state_n;
      r_deb_cnt   <= w_deb_n;
      r_hold_cnt  <= w_hold_n;
      r_ev_press  <= w_ev_press;
      r_ev_rel    <= w_ev_rel;
      r_ev_short  <= w_ev_short;
      r_ev_long   <= w_ev_long;
      r_btn_level <= w_held;
      r_press     <= r_ev_press;
      r_rel       <= r_ev_rel;
      r_short     <= r_ev_short;
      r_long      <= r_ev_long;
    end
  end
  assign btn.btn_level         = r_btn_level;
  assign btn.press_pulse       = r_press;
  assign btn.release_pulse     = r_rel;
  assign btn.short_press_pulse = r_short;
  assign btn.long_press_pulse  = r_long;
endmodule
